cskip_sub32_seq: RTL and testbench
==================================

# cskip_sub32_seq

Multi-cycle 32-bit subtractor that computes `a - b` one 4-bit group per clock. It forms `a + ~b + 1` through a single 4-bit ripple slice with carry-skip bypass, and registers the carry between groups. It is the subtract-side companion to the 32-bit carry-skip adder and sits behind a valid/ready operand port and a valid/ready result port. It trades latency for one group's worth of adder hardware.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. Must be a multiple of `GROUP`.
- `GROUP`, 4: bits processed per RUN cycle. `NGRP = WIDTH/GROUP` (8 at defaults).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands present on `a`/`b`.
- `in_ready`  out  1  block can accept operands (high only in IDLE).
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `out_valid`  out  1  result valid (high only in DONE).
- `out_ready`  in  1  consumer takes result.
- `diff`  out  WIDTH  `(a - b) mod 2^WIDTH`.
- `borrow`  out  1  1 when unsigned `a < b` (inverted final carry).
- `ovf`  out  1  signed overflow; present only with `CSKIP_SUB_OVF_EN`.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: `in_ready=1`. On `in_valid & in_ready`:
  - latch `a` and `~b` into operand shift registers;
  - set the carry register to 1;
  - clear the group counter `k` to 0;
  - go to RUN.
- RUN: slice inputs are `A_k = a[k*GROUP +: GROUP]`, `B_k = ~b[k*GROUP +: GROUP]`, and `c`.
  - `diff[k*GROUP +: GROUP] <= A_k + B_k + c` (low GROUP bits).
  - Skip logic: `P = &(A_k ^ B_k)`. Next carry is `c` if `P`, else the ripple carry-out. Both paths must give an identical value.
  - `k` increments each cycle. At `k = NGRP-1`, go to DONE and register `borrow <= ~carry_out`.
- DONE: `out_valid=1`. `diff`/`borrow`/`ovf` are held stable until `out_valid & out_ready`, then the block returns to IDLE.
- `in_valid` is ignored outside IDLE. `a`/`b` need only be stable on the accept edge.
- `out_ready` is ignored outside DONE.
- No overlap of operations: accept is never possible in the same cycle as result handoff.

## Timing
- Reset (asynchronous assert, any state):
  - state IDLE, `k=0`, carry 1;
  - `diff=0`, `borrow=0`, `ovf=0`;
  - `in_ready=1`, `out_valid=0`.
- Reset mid-RUN aborts the operation. No result is produced.
- Latency: accept at edge E0; groups are written on E1..E`NGRP`; `out_valid` is high in the cycle after E`NGRP` (8 cycles after accept at defaults).
- `in_ready` falls in the cycle after the accept edge and rises in the cycle after the handoff edge.
- Minimum initiation interval is `NGRP+2` cycles (10 at defaults) with `out_ready` held high.
- `diff` bits during RUN are partially updated and undefined to consumers. Only values under `out_valid` are meaningful.
- Wrap-around of `k` never occurs. The RUN→DONE transition takes priority at `k = NGRP-1`.

## Configuration
- `CSKIP_SUB_OVF_EN` defined:
  - `ovf` port exists;
  - on the last RUN cycle, `ovf <= (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1])`;
  - held in DONE, cleared by reset only.
- Not defined: `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
- `a=0x00000005`, `b=0x00000003` -> `diff=0x00000002`, `borrow=0`, `out_valid` exactly 8 cycles after accept.
- `a=0x00000000`, `b=0x00000001` -> `diff=0xFFFFFFFF`, `borrow=1`, `ovf=0`.
- `a=0x80000000`, `b=0x00000001` -> `diff=0x7FFFFFFF`, `borrow=0`, `ovf=1` (with macro).
- `a=b=0x12345678` (all groups propagate, skip path every cycle) -> `diff=0`, `borrow=0`.
- Hold `out_ready=0` for 5 cycles in DONE -> outputs stable, `in_ready=0`, new `in_valid` ignored. Then `out_ready=1` -> IDLE next cycle, and the next operand is accepted one cycle later.
- Deassert `rst_n` at RUN `k=3` -> all outputs at reset values immediately. After release, `0x10-0x01` yields `diff=0x0000000F`, `borrow=0`.

Source files
------------

// File: rtl/cskip_sub32_seq.sv
// cskip_sub32_seq -- multi-cycle subtractor, one GROUP-bit slice per clock.
//
// Computes diff = a - b as a + ~b + 1 through a single carry-skip slice.
// The carry is registered between groups. Operands enter on a valid/ready port
// and the result leaves on a valid/ready port. Only one operation is in flight.
//
// Parameters:
//   WIDTH  operand/result width. Must be a multiple of GROUP, with WIDTH/GROUP >= 2.
//   GROUP  bits processed per RUN cycle.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready is high only in IDLE)
//   a, b                  minuend and subtrahend; sampled on the accept edge
//   out_valid / out_ready result handshake (out_valid is high only in DONE)
//   diff                  (a - b) mod 2^WIDTH
//   borrow                1 when unsigned a < b
//   ovf                   signed overflow; present only when CSKIP_SUB_OVF_EN is defined
//
// Optional feature macro: CSKIP_SUB_OVF_EN (adds the ovf port and its logic).

// One GROUP-bit ripple slice with a carry-skip bypass. When every bit
// propagates, the carry-out equals the carry-in. The bypass selects that
// directly, and it gives the same value as the ripple chain.
module cskip_slice #(
  parameter int G = 4
) (
  input  logic [G-1:0] x,
  input  logic [G-1:0] y,
  input  logic         cin,
  output logic [G-1:0] sum,
  output logic         cout
);
  logic [G:0]   cc;
  logic [G-1:0] p;

  assign cc[0] = cin;
  assign p     = x ^ y;

  for (genvar i = 0; i < G; i++) begin : g_rip
    assign sum[i]  = p[i] ^ cc[i];
    assign cc[i+1] = (x[i] & y[i]) | (cc[i] & p[i]);
  end

  assign cout = (&p) ? cin : cc[G];
endmodule

module cskip_sub32_seq #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef CSKIP_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NGRP = WIDTH / GROUP;
  localparam int KW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic             carry;
  // Operands shift right one group per RUN cycle. The active group is always
  // in the low GROUP bits, so the slice needs no wide mux.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;   // holds ~b

  logic [GROUP-1:0] s_sum;
  logic             s_cout;
  logic             last;

  cskip_slice #(.G(GROUP)) u_slice (
    .x    (a_sh[GROUP-1:0]),
    .y    (b_sh[GROUP-1:0]),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );

  assign last      = (k == KW'(NGRP - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      carry  <= 1'b1;
      a_sh   <= '0;
      b_sh   <= '0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef CSKIP_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= ~b;
            carry <= 1'b1;   // the +1 of the two's-complement negation
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> GROUP;
          b_sh  <= b_sh >> GROUP;
          // Result groups enter from the top. After NGRP cycles, group k sits at k*GROUP.
          diff  <= {s_sum, diff[WIDTH-1:GROUP]};
          carry <= s_cout;
          if (last) begin
            k      <= '0;
            state  <= DONE;
            borrow <= ~s_cout;
`ifdef CSKIP_SUB_OVF_EN
            // The top group is in the slice. a's sign bit is x[GROUP-1],
            // and b's sign bit is the inverse of y[GROUP-1].
            ovf    <= (a_sh[GROUP-1] == b_sh[GROUP-1]) & (s_sum[GROUP-1] != a_sh[GROUP-1]);
`endif
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cskip_sub32_seq.sv
module tb_cskip_sub32_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] diff;
  logic        borrow;
`ifdef CSKIP_SUB_OVF_EN
  logic        ovf;
`endif

  cskip_sub32_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef CSKIP_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pop the expected result whenever a result is handed off.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got 0x%08h expected none", diff);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", diff, e.diff);
        chk("borrow", {31'b0, borrow}, {31'b0, e.borrow});
`ifdef CSKIP_SUB_OVF_EN
        chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
`endif
      end
    end
  end

  // Drive one operand pair. Assumes the caller is positioned at #1 after a posedge.
  task automatic send(input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] ed, input logic eb, input logic eo, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: in_ready=%0b expected 1", in_ready);
    end
    a = va; b = vb; in_valid = 1'b1;
    if (push) q.push_back('{diff: ed, borrow: eb, ovf: eo});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  initial begin
    int n;
    logic [31:0] held;

    // Reset state
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_diff", diff, 32'd0);
    chk("rst_borrow", {31'b0, borrow}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 5 - 3, with latency measured from the accept edge
    send(32'h5, 32'h3, 32'h2, 1'b0, 1'b0, 1'b1);
    chk("in_ready_after_accept", {31'b0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, 32'd8);
    drain();

    send(32'h0, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    drain();
    send(32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
    drain();
    send(32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b1);
    drain();
    send(32'h1, 32'hFFFF_FFFF, 32'h2, 1'b1, 1'b0, 1'b1);
    drain();
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    drain();

    // Back-pressure: hold out_ready low in DONE and offer a new operand meanwhile
    out_ready = 1'b0;
    send(32'h100, 32'h1, 32'hFF, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk("hold_reach_done", {31'b0, out_valid}, 32'd1);
    held = diff;
    a = 32'hDEAD_BEEF; b = 32'h1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_diff", diff, 32'hFF);
      chk("hold_stable", diff, held);
      chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;   // handoff edge
    chk("idle_after_handoff", {31'b0, in_ready}, 32'd1);
    chk("no_valid_after_handoff", {31'b0, out_valid}, 32'd0);
    chk("hold_popped", q.size(), 32'd0);
    send(32'h20, 32'h1, 32'h1F, 1'b0, 1'b0, 1'b1);
    chk("next_accepted", {31'b0, in_ready}, 32'd0);
    drain();

    // Reset mid-RUN at k=3: the operation is aborted and produces no result
    send(32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_diff", diff, 32'd0);
    chk("abort_borrow", {31'b0, borrow}, 32'd0);
`ifdef CSKIP_SUB_OVF_EN
    chk("abort_ovf", {31'b0, ovf}, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h10, 32'h01, 32'hF, 1'b0, 1'b0, 1'b1);
    drain();
    repeat (12) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
